// File: rtl/series_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : series_sequencer                                              |
// | Purpose  : Plays one of four built-in note series into the note divider, |
// |            pausing while a keypad note is held. Optional macro:          |
// |            SERIES_GAP_EN (rest for the last GAP_CYCLES of every note).   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module series_sequencer #(
    parameter int BEAT_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [1:0] series_sel,
    input  logic [3:0] keycode,
    output logic [3:0] sound_series,
    output logic [2:0] note_idx,
    output logic       busy,
    output logic       done
);

    localparam int            CW     = $clog2(7 * BEAT_CYCLES);
    localparam logic [CW-1:0] c_beat = CW'(BEAT_CYCLES);
    localparam logic [CW-1:0] c_one  = CW'(1);
    localparam logic [3:0]    c_rest = 4'b1111;
`ifdef SERIES_GAP_EN
    localparam logic [CW-1:0] c_gap  = CW'(GAP_CYCLES);
`endif

    // Entry = {beats[2:0], note[3:0]}, addressed by {series, index}; beats = 0 ends a series.
    localparam logic [6:0] c_rom [32] = '{
        7'h10, 7'h12, 7'h14, 7'h15, 7'h17, 7'h19, 7'h1B, 7'h1C,
        7'h2C, 7'h27, 7'h24, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h19, 7'h19, 7'h19, 7'h35, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h10, 7'h2F, 7'h10, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

    if (BEAT_CYCLES < 2 || GAP_CYCLES < 1 || GAP_CYCLES >= BEAT_CYCLES) begin : g_param_check
        $error("series_sequencer: need BEAT_CYCLES >= 2 and 1 <= GAP_CYCLES < BEAT_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t        r_state, w_state_next;
    logic [1:0]    r_sel, w_sel_next;
    logic [3:0]    r_idx, w_idx_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [3:0]    r_note, w_note_next;
    logic [3:0]    r_sound, w_sound_next;
    logic          r_busy, r_done, w_done_next;
    logic [6:0]    w_entry;
    logic [2:0]    w_la_beats;
    logic          w_end, w_la_end;

    function automatic logic [3:0] sanitise(input logic [3:0] n);
        return (n == 4'd13 || n == 4'd14) ? c_rest : n;
    endfunction

    assign w_entry = c_rom[{r_sel, r_idx[2:0]}];
    assign w_end   = r_idx[3] | (w_entry[6:4] == 3'd0);

    // Outputs are registered, so the end-of-series check is looked ahead one
    // cycle: done is raised on entry to the FETCH that will terminate.
    assign w_la_beats = c_rom[{w_sel_next, w_idx_next[2:0]}][6:4];
    assign w_la_end   = w_idx_next[3] | (w_la_beats == 3'd0);

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_note_next  = r_note;
        w_sound_next = c_rest;
        w_done_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && en && !stop) begin
                    w_state_next = ST_FETCH;
                    w_sel_next   = series_sel;
                    w_idx_next   = 4'd0;
                end
            end
            ST_FETCH: begin
                if (r_done) begin
                    w_state_next = ST_IDLE;
                end else if (w_end) begin
                    w_idx_next = 4'd0;
                end else begin
                    w_note_next  = sanitise(w_entry[3:0]);
                    w_cnt_next   = c_beat * CW'(w_entry[6:4]) - c_one;
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (r_cnt == '0) begin
                    w_idx_next   = r_idx + 4'd1;
                    w_state_next = ST_FETCH;
                end else begin
                    w_cnt_next = r_cnt - c_one;
                    if (keycode != c_rest) begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            default: begin
                if (keycode == c_rest) begin
                    w_state_next = ST_PLAY;
                end
            end
        endcase

        if (r_state != ST_IDLE && (!en || stop)) begin
            w_state_next = ST_IDLE;
        end
        if (w_state_next == ST_IDLE) begin
            w_idx_next = 4'd0;
        end

        if (w_state_next == ST_PLAY) begin
            w_sound_next = w_note_next;
`ifdef SERIES_GAP_EN
            if (w_cnt_next < c_gap) begin
                w_sound_next = c_rest;
            end
`endif
        end

        // An end marker reached through a loop restart (index 0) always finishes.
        w_done_next = (w_state_next == ST_FETCH) && w_la_end &&
                      (!loop || w_idx_next == 4'd0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_note  <= 4'd0;
            r_sound <= c_rest;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_note  <= w_note_next;
            r_sound <= w_sound_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= w_done_next;
        end
    end

    assign sound_series = r_sound;
    assign note_idx     = r_idx[2:0];
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire
